// File: rtl/rv_regfile_mp_if.sv
// Bus bundle between decode/writeback and the rv_regfile_mp register file.
// Handshake: i_write and i_rs_en are only honoured while o_ready=1; once ready, every enabled request completes in one cycle with no backpressure.
interface rv_regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   i_rs_addr;
  logic [NRD-1:0]      i_rs_en;
  logic [AW-1:0]       i_rd;
  logic                i_write;
  logic [XLEN-1:0]     i_data;
  logic [NRD*XLEN-1:0] o_data;
  logic                o_ready;

  modport master (
    output i_rs_addr, i_rs_en, i_rd, i_write, i_data,
    input  o_data, o_ready
  );

  modport slave (
    input  i_rs_addr, i_rs_en, i_rd, i_write, i_data,
    output o_data, o_ready
  );
endinterface

// File: rtl/rv_regfile_mp.sv
// Multi-read-port integer register file: registered reads, one write port, x0 reads zero,
// storage cleared by a sequencer after reset. Optional write-first bypass: RF_BYPASS_EN.
module rv_regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  rv_regfile_mp_if.slave  bus,
  output logic            dbg_state
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t              state;
  logic [AW-1:0]       clr_cnt;
  logic                ready;
  logic [NRD*XLEN-1:0] rd_data;
  logic [XLEN-1:0]     mem [NREGS];

  assign bus.o_data  = rd_data;
  assign bus.o_ready = ready;
  assign dbg_state   = state;

  // No reset on the array so it can map to RAM; entry 0 is never written and never read.
  always_ff @(posedge i_clk) begin
    if (state == S_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (bus.i_write && (bus.i_rd != '0)) begin
      mem[bus.i_rd] <= bus.i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= S_CLEAR;
      clr_cnt <= AW'(1);
      ready   <= 1'b0;
      rd_data <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(NREGS - 1)) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        S_RUN: begin
          for (int p = 0; p < NRD; p++) begin
            if (bus.i_rs_en[p]) begin
              if (bus.i_rs_addr[p*AW +: AW] == '0) begin
                rd_data[p*XLEN +: XLEN] <= '0;
`ifdef RF_BYPASS_EN
              end else if (bus.i_write && (bus.i_rd == bus.i_rs_addr[p*AW +: AW])) begin
                rd_data[p*XLEN +: XLEN] <= bus.i_data;
`endif
              end else begin
                rd_data[p*XLEN +: XLEN] <= mem[bus.i_rs_addr[p*AW +: AW]];
              end
            end
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_regfile_mp.sv
// Self-checking bench for rv_regfile_mp: default 2R/32-entry instance plus a 3R/16-entry instance.
module tb_rv_regfile_mp;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic dbg_a, dbg_b;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem_a [32];
  logic [31:0] out_a [2];
  logic [31:0] mem_b [16];
  logic [31:0] out_b [3];

  rv_regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ba ();
  rv_regfile_mp_if #(.XLEN(32), .NREGS(16), .NRD(3)) bb ();

  rv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .bus(ba), .dbg_state(dbg_a)
  );
  rv_regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bb), .dbg_state(dbg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ba.i_rs_addr = '0; ba.i_rs_en = '0; ba.i_rd = '0; ba.i_write = 1'b0; ba.i_data = '0;
    bb.i_rs_addr = '0; bb.i_rs_en = '0; bb.i_rd = '0; bb.i_write = 1'b0; bb.i_data = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem_a[i] = '0;
    for (int i = 0; i < 16; i++) mem_b[i] = '0;
    for (int p = 0; p < 2; p++) out_a[p] = '0;
    for (int p = 0; p < 3; p++) out_b[p] = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy_a"}, {31'd0, ba.o_ready}, 32'd0);
    check({tag, "_rdy_b"}, {31'd0, bb.o_ready}, 32'd0);
    for (int p = 0; p < 2; p++) check({tag, "_dat_a"}, ba.o_data[p*32 +: 32], 32'd0);
    for (int p = 0; p < 3; p++) check({tag, "_dat_b"}, bb.o_data[p*32 +: 32], 32'd0);
  endtask

  // Counts edges after release until each o_ready rises; optionally throws junk writes/reads during CLEAR.
  task automatic wait_ready(input bit junk, output int ea, output int eb);
    ea = 0;
    eb = 0;
    for (int i = 1; i <= 40 && (ea == 0 || eb == 0); i++) begin
      if (junk && ea == 0) begin
        ba.i_write = 1'b1; ba.i_rd = 5'($urandom_range(1, 31)); ba.i_data = $urandom;
        ba.i_rs_en = '1; ba.i_rs_addr = 10'($urandom);
      end
      if (junk && eb == 0) begin
        bb.i_write = 1'b1; bb.i_rd = 4'($urandom_range(1, 15)); bb.i_data = $urandom;
        bb.i_rs_en = '1; bb.i_rs_addr = 12'($urandom);
      end
      @(posedge clk); #1;
      if (ea == 0) begin
        check("clr_dat_a", ba.o_data[31:0] | ba.o_data[63:32], 32'd0);
        if (ba.o_ready) begin
          ea = i; ba.i_write = 1'b0; ba.i_rs_en = '0;
        end
      end
      if (eb == 0) begin
        check("clr_dat_b", bb.o_data[31:0] | bb.o_data[63:32] | bb.o_data[95:64], 32'd0);
        if (bb.o_ready) begin
          eb = i; bb.i_write = 1'b0; bb.i_rs_en = '0;
        end
      end
    end
    idle_inputs();
  endtask

  // driver for the 2-port instance; expected read data pushed at drive time, popped after the edge
  task automatic step_a(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] en,
                        input logic wr, input logic [4:0] rd, input logic [31:0] d);
    logic [4:0]  ad [2];
    logic [31:0] e;
    ad[0] = a0; ad[1] = a1;
    ba.i_rs_addr = {a1, a0}; ba.i_rs_en = en; ba.i_write = wr; ba.i_rd = rd; ba.i_data = d;
    for (int p = 0; p < 2; p++) begin
      if (!en[p])                               e = out_a[p];
      else if (ad[p] == 5'd0)                   e = 32'd0;
      else if (BYP && wr && rd == ad[p])        e = d;
      else                                      e = mem_a[ad[p]];
      out_a[p] = e;
      exp_q.push_back(e);
    end
    if (wr && rd != 5'd0) mem_a[rd] = d;
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) check($sformatf("a_port%0d", p), ba.o_data[p*32 +: 32], exp_q.pop_front());
    ba.i_write = 1'b0; ba.i_rs_en = '0;
  endtask

  task automatic step_b(input logic [11:0] addrs, input logic [2:0] en,
                        input logic wr, input logic [3:0] rd, input logic [31:0] d);
    logic [3:0]  ad;
    logic [31:0] e;
    bb.i_rs_addr = addrs; bb.i_rs_en = en; bb.i_write = wr; bb.i_rd = rd; bb.i_data = d;
    for (int p = 0; p < 3; p++) begin
      ad = addrs[p*4 +: 4];
      if (!en[p])                               e = out_b[p];
      else if (ad == 4'd0)                      e = 32'd0;
      else if (BYP && wr && rd == ad)           e = d;
      else                                      e = mem_b[ad];
      out_b[p] = e;
      exp_q.push_back(e);
    end
    if (wr && rd != 4'd0) mem_b[rd] = d;
    @(posedge clk); #1;
    for (int p = 0; p < 3; p++) check($sformatf("b_port%0d", p), bb.o_data[p*32 +: 32], exp_q.pop_front());
    bb.i_write = 1'b0; bb.i_rs_en = '0;
  endtask

  initial begin
    int ea, eb;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    wait_ready(1'b0, ea, eb);
    check("ready_edges_a", 32'(ea), 32'd31);
    check("ready_edges_b", 32'(eb), 32'd15);
    check("state_run_a", {31'd0, dbg_a}, 32'd1);

    // cleared contents read as zero
    for (int i = 1; i < 32; i++) step_a(5'(i), 5'(31 - i), 2'b11, 1'b0, 5'd0, 32'd0);

    // write then read, x0 on the other port
    step_a(5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 32'hDEADBEEF);
    step_a(5'd5, 5'd0, 2'b11, 1'b0, 5'd0, 32'd0);
    // x0 stays zero
    step_a(5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 32'hFFFFFFFF);
    step_a(5'd0, 5'd0, 2'b11, 1'b0, 5'd0, 32'd0);
    // same-cycle write/read of x7
    step_a(5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 32'h11);
    step_a(5'd7, 5'd7, 2'b01, 1'b1, 5'd7, 32'h22);
    step_a(5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 32'd0);
    // hold with enable low
    step_a(5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 32'hA5A5A5A5);
    step_a(5'd3, 5'd5, 2'b11, 1'b0, 5'd0, 32'd0);
    step_a(5'd9, 5'd5, 2'b00, 1'b1, 5'd3, 32'd0);
    step_a(5'd3, 5'd3, 2'b00, 1'b0, 5'd0, 32'd0);

    // random traffic
    for (int n = 0; n < 300; n++)
      step_a(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    for (int n = 0; n < 150; n++)
      step_b(12'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), $urandom);
    step_b({4'd6, 4'd6, 4'd6}, 3'b000, 1'b1, 4'd6, 32'h0BADF00D);
    step_b({4'd6, 4'd0, 4'd6}, 3'b111, 1'b0, 4'd0, 32'd0);

    // fill every entry, then reset mid-run
    for (int i = 1; i < 32; i++) step_a(5'd0, 5'd0, 2'b00, 1'b1, 5'(i), 32'(i));
    for (int i = 1; i < 16; i++) step_b(12'd0, 3'b000, 1'b1, 4'(i), 32'(i));
    step_a(5'd31, 5'd17, 2'b11, 1'b0, 5'd0, 32'd0);
    step_b({4'd15, 4'd8, 4'd1}, 3'b111, 1'b0, 4'd0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    wait_ready(1'b1, ea, eb);
    check("ready_edges2_a", 32'(ea), 32'd31);
    check("ready_edges2_b", 32'(eb), 32'd15);
    for (int i = 1; i < 32; i++) step_a(5'(i), 5'(i), 2'b11, 1'b0, 5'd0, 32'd0);
    for (int i = 1; i < 16; i++) step_b({4'(i), 4'(16 - i), 4'(i)}, 3'b111, 1'b0, 4'd0, 32'd0);
    check("final_rdy_a", {31'd0, ba.o_ready}, 32'd1);
    check("final_rdy_b", {31'd0, bb.o_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
